// File: rtl/fe_pkg.sv
// Shared types and helpers for the field-element multiplier arbiter.
package fe_pkg;

    localparam int FE_W = 320;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fe_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    always_comb begin
        int               w_cand;
        logic [IDX_W-1:0] w_cidx;
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        w_cidx  = '0;
        for (int o = 0; o < NUM_REQ; o++) begin
            w_cand = int'(i_ptr) + o;
            if (w_cand >= NUM_REQ)
                w_cand = w_cand - NUM_REQ;
            w_cidx = IDX_W'(w_cand);
            if (!o_valid && i_req[w_cidx]) begin
                o_valid = 1'b1;
                o_idx   = w_cidx;
            end
        end
    end

endmodule

// File: rtl/fe_mul_arbiter.sv
// Round-robin sharing of one fe_mul between NUM_REQ sequencers.
// Optional grant lock for atomic back-to-back ops: define FE_MUL_ARB_LOCK_EN.
module fe_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int FE_W    = fe_pkg::FE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      req_lock,
    input  logic [NUM_REQ*FE_W-1:0] f_in,
    input  logic [NUM_REQ*FE_W-1:0] g_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [FE_W-1:0]         rsp_h,
    output logic                    busy,
    output logic [FE_W-1:0]         mul_f,
    output logic [FE_W-1:0]         mul_g,
    output logic                    mul_start,
    input  logic                    mul_done,
    input  logic [FE_W-1:0]         mul_h
);
    import fe_pkg::*;

    localparam int IDX_W = idx_w(NUM_REQ);

    arb_state_t          r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_cur;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [FE_W-1:0]     r_rsp_h;
    logic [FE_W-1:0]     r_mul_f;
    logic [FE_W-1:0]     r_mul_g;
    logic                r_mul_start;

    logic                w_pick_vld;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_win_vld;
    logic [IDX_W-1:0]    w_win_idx;
    logic [NUM_REQ-1:0]  w_win_oh;
    logic [NUM_REQ-1:0]  w_cur_oh;
    logic [FE_W-1:0]     w_f_sel;
    logic [FE_W-1:0]     w_g_sel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

`ifdef FE_MUL_ARB_LOCK_EN
    logic r_lock;
    logic w_lock_hit;
    // A locked owner still requesting bypasses the rotation pointer.
    assign w_lock_hit = r_lock && req[r_cur];
    assign w_win_vld  = w_lock_hit || w_pick_vld;
    assign w_win_idx  = w_lock_hit ? r_cur : w_pick_idx;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
    assign w_win_vld     = w_pick_vld;
    assign w_win_idx     = w_pick_idx;
`endif

    assign w_win_oh = NUM_REQ'(1) << w_win_idx;
    assign w_cur_oh = NUM_REQ'(1) << r_cur;

    always_comb begin
        w_f_sel = '0;
        w_g_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == IDX_W'(i)) begin
                w_f_sel = f_in[i*FE_W +: FE_W];
                w_g_sel = g_in[i*FE_W +: FE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_cur       <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_h     <= '0;
            r_mul_f     <= '0;
            r_mul_g     <= '0;
            r_mul_start <= 1'b0;
`ifdef FE_MUL_ARB_LOCK_EN
            r_lock      <= 1'b0;
`endif
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_mul_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_vld) begin
                        r_cur       <= w_win_idx;
                        r_mul_f     <= w_f_sel;
                        r_mul_g     <= w_g_sel;
                        r_gnt       <= w_win_oh;
                        r_mul_start <= 1'b1;
                        r_state     <= ISSUE;
`ifdef FE_MUL_ARB_LOCK_EN
                        r_lock      <= req_lock[w_win_idx];
                    end else begin
                        r_lock      <= 1'b0;
`endif
                    end
                end
                ISSUE: r_state <= WAIT;
                // mul_done only matters here; stray pulses elsewhere are dropped.
                WAIT: begin
                    if (mul_done) begin
                        r_rsp_h     <= mul_h;
                        r_rsp_valid <= w_cur_oh;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_ptr   <= (r_cur == IDX_W'(NUM_REQ-1)) ? '0 : r_cur + 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_h     = r_rsp_h;
    assign mul_f     = r_mul_f;
    assign mul_g     = r_mul_g;
    assign mul_start = r_mul_start;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_fe_mul_arbiter.sv
// Directed bench for fe_mul_arbiter with a fixed-latency fe_mul stub.
module tb_fe_mul_arbiter;

    localparam int NUM_REQ = 4;
    localparam int FE_W    = 320;
    localparam int LAT     = 5;

    logic                    clk;
    logic                    rst;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      req_lock;
    logic [NUM_REQ*FE_W-1:0] f_in;
    logic [NUM_REQ*FE_W-1:0] g_in;
    logic [NUM_REQ-1:0]      gnt;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [FE_W-1:0]         rsp_h;
    logic                    busy;
    logic [FE_W-1:0]         mul_f;
    logic [FE_W-1:0]         mul_g;
    logic                    mul_start;
    logic                    mul_done;
    logic [FE_W-1:0]         mul_h;

    logic [3:0]      stub_cnt;
    logic            stub_done;
    logic [FE_W-1:0] stub_h, stub_f, stub_g;
    logic            frc_done;
    logic [FE_W-1:0] frc_h;

    int checks;
    int errors;
    int overlap_cnt;

    fe_mul_arbiter #(.NUM_REQ(NUM_REQ), .FE_W(FE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_lock  (req_lock),
        .f_in      (f_in),
        .g_in      (g_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_h     (rsp_h),
        .busy      (busy),
        .mul_f     (mul_f),
        .mul_g     (mul_g),
        .mul_start (mul_start),
        .mul_done  (mul_done),
        .mul_h     (mul_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // fe_mul stub: product appears LAT cycles after the start pulse.
    always @(posedge clk) begin
        if (rst) begin
            stub_cnt  <= '0;
            stub_done <= 1'b0;
        end else begin
            stub_done <= 1'b0;
            if (mul_start) begin
                stub_cnt <= 4'(LAT);
                stub_f   <= mul_f;
                stub_g   <= mul_g;
            end else if (stub_cnt != 0) begin
                stub_cnt <= stub_cnt - 1'b1;
                if (stub_cnt == 1) begin
                    stub_done <= 1'b1;
                    stub_h    <= stub_f * stub_g;
                end
            end
        end
    end

    assign mul_done = stub_done | frc_done;
    assign mul_h    = frc_done ? frc_h : stub_h;

    always @(negedge clk)
        if (gnt != 0 && rsp_valid != 0) overlap_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; req_lock = '0; frc_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_op(input int i, input int f, input int g);
        f_in[i*FE_W +: FE_W] = FE_W'(f);
        g_in[i*FE_W +: FE_W] = FE_W'(g);
    endtask

    task automatic wait_gnt(output int idx, output bit ok);
        ok = 1'b0; idx = -1;
        for (int c = 0; c < 40; c++) begin
            if (gnt != 0) begin
                ok = 1'b1;
                for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) idx = i;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_rsp(output logic [NUM_REQ-1:0] v, output logic [FE_W-1:0] h, output bit ok);
        ok = 1'b0; v = '0; h = '0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid != 0) begin
                ok = 1'b1; v = rsp_valid; h = rsp_h;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({gnt, rsp_valid, mul_start, busy} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl gnt=%b rsp_valid=%b start=%b busy=%b want all 0", gnt, rsp_valid, mul_start, busy);
        end
        checks++;
        if ((rsp_h | mul_f | mul_g) !== '0) begin
            errors++;
            $display("FAIL reset_data rsp_h=%0d mul_f=%0d mul_g=%0d want 0", rsp_h, mul_f, mul_g);
        end
    endtask

    task automatic test_single();
        int  starts;
        bit  bad;
        f_in = '0; g_in = '0;
        do_reset();
        set_op(2, 2, 3);
        req = 4'b0100;
        tick();
        checks++;
        if (gnt !== 4'b0100 || mul_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue gnt=%b start=%b busy=%b want 0100 1 1", gnt, mul_start, busy);
        end
        checks++;
        if (mul_f !== FE_W'(2) || mul_g !== FE_W'(3)) begin
            errors++;
            $display("FAIL single_ops mul_f=%0d mul_g=%0d want 2 3", mul_f, mul_g);
        end
        req = '0; starts = 0; bad = 1'b0;
        tick();
        checks++;
        if (gnt !== '0 || mul_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_wait gnt=%b start=%b busy=%b want 0000 0 1", gnt, mul_start, busy);
        end
        for (int c = 0; c < 40; c++) begin
            if (mul_done) break;
            if (rsp_valid != 0 || busy !== 1'b1) bad = 1'b1;
            if (mul_start) starts++;
            tick();
        end
        checks++;
        if (mul_done !== 1'b1 || bad || starts != 0) begin
            errors++;
            $display("FAIL single_done done=%b early_rsp_or_idle=%0d extra_starts=%0d want 1 0 0", mul_done, bad, starts);
        end
        tick();
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_h !== FE_W'(6) || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_rsp rsp_valid=%b rsp_h=%0d busy=%b want 0100 6 1", rsp_valid, rsp_h, busy);
        end
        tick();
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || rsp_h !== FE_W'(6)) begin
            errors++;
            $display("FAIL single_hold rsp_valid=%b busy=%b rsp_h=%0d want 0000 0 6", rsp_valid, busy, rsp_h);
        end
    endtask

    task automatic test_round_robin();
        int exp_idx [5] = '{0, 1, 2, 3, 0};
        int exp_h   [5] = '{10, 18, 28, 40, 10};
        int idx;
        bit ok;
        logic [NUM_REQ-1:0] v, ev;
        logic [FE_W-1:0]    h;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, i + 2, i + 5);
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_gnt(idx, ok);
            checks++;
            if (!ok || idx != exp_idx[n]) begin
                errors++;
                $display("FAIL rr_gnt%0d got=%0d want=%0d", n, idx, exp_idx[n]);
            end
            if (n == 4) req = '0;
            wait_rsp(v, h, ok);
            ev = NUM_REQ'(1) << exp_idx[n];
            checks++;
            if (!ok || v !== ev || h !== FE_W'(exp_h[n])) begin
                errors++;
                $display("FAIL rr_rsp%0d rsp_valid=%b rsp_h=%0d want %b %0d", n, v, h, ev, exp_h[n]);
            end
        end
        tick();
    endtask

    task automatic test_no_starve();
        int exp_idx [3] = '{1, 3, 1};
        int exp_h   [3] = '{18, 40, 18};
        int idx;
        bit ok;
        logic [NUM_REQ-1:0] v, ev;
        logic [FE_W-1:0]    h;
        do_reset();
        req = 4'b0010;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(idx, ok);
            checks++;
            if (!ok || idx != exp_idx[n]) begin
                errors++;
                $display("FAIL starve_gnt%0d got=%0d want=%0d", n, idx, exp_idx[n]);
            end
            req = (n == 2) ? 4'b0000 : 4'b1010;
            wait_rsp(v, h, ok);
            ev = NUM_REQ'(1) << exp_idx[n];
            checks++;
            if (!ok || v !== ev || h !== FE_W'(exp_h[n])) begin
                errors++;
                $display("FAIL starve_rsp%0d rsp_valid=%b rsp_h=%0d want %b %0d", n, v, h, ev, exp_h[n]);
            end
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        int idx;
        bit ok, bad;
        logic [NUM_REQ-1:0] v;
        logic [FE_W-1:0]    h;
        do_reset();
        set_op(2, 2, 3); set_op(0, 7, 6); set_op(3, 5, 8);
        req = 4'b0100;
        wait_gnt(idx, ok);
        req = '0;
        wait_rsp(v, h, ok);
        tick();
        req = 4'b0001;
        wait_gnt(idx, ok);
        req = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({gnt, rsp_valid, mul_start, busy} !== '0 || (rsp_h | mul_f | mul_g) !== '0) begin
            errors++;
            $display("FAIL midreset_outs gnt=%b rsp_valid=%b start=%b busy=%b rsp_h=%0d mul_f=%0d want all 0",
                     gnt, rsp_valid, mul_start, busy, rsp_h, mul_f);
        end
        tick();
        frc_done = 1'b1; frc_h = FE_W'(99);
        tick();
        frc_done = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid != 0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_stale_done saw rsp_valid or busy after reset, want none");
        end
        req = 4'b1001;
        wait_gnt(idx, ok);
        checks++;
        if (!ok || idx != 0) begin
            errors++;
            $display("FAIL midreset_ptr got=%0d want=0", idx);
        end
        req = '0;
        wait_rsp(v, h, ok);
        checks++;
        if (!ok || v !== 4'b0001 || h !== FE_W'(42)) begin
            errors++;
            $display("FAIL midreset_rsp rsp_valid=%b rsp_h=%0d want 0001 42", v, h);
        end
        tick();
    endtask

    task automatic test_spurious_done();
        int idx;
        bit ok;
        logic [NUM_REQ-1:0] v;
        logic [FE_W-1:0]    h;
        frc_done = 1'b1; frc_h = FE_W'(123);
        tick();
        frc_done = 1'b0;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle rsp_valid=%b busy=%b want 0000 0", rsp_valid, busy);
        end
        set_op(0, 9, 9);
        req = 4'b0001;
        wait_gnt(idx, ok);
        req = '0;
        // Stray done during ISSUE must also be dropped.
        frc_done = 1'b1; frc_h = FE_W'(123);
        tick();
        frc_done = 1'b0;
        wait_rsp(v, h, ok);
        checks++;
        if (!ok || v !== 4'b0001 || h !== FE_W'(81)) begin
            errors++;
            $display("FAIL spur_rsp rsp_valid=%b rsp_h=%0d want 0001 81", v, h);
        end
        tick();
    endtask

    task automatic test_lock();
`ifdef FE_MUL_ARB_LOCK_EN
        int exp_idx [3] = '{0, 0, 1};
`else
        int exp_idx [3] = '{0, 1, 0};
`endif
        int idx;
        bit ok;
        logic [NUM_REQ-1:0] v;
        logic [FE_W-1:0]    h;
        do_reset();
        set_op(0, 3, 4); set_op(1, 5, 5);
        req = 4'b0011; req_lock = 4'b0001;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(idx, ok);
            checks++;
            if (!ok || idx != exp_idx[n]) begin
                errors++;
                $display("FAIL lock_gnt%0d got=%0d want=%0d", n, idx, exp_idx[n]);
            end
            req_lock = '0;
            if (n == 2) req = '0;
            wait_rsp(v, h, ok);
        end
        checks++;
        if (!ok || h !== FE_W'((exp_idx[2] == 0) ? 12 : 25)) begin
            errors++;
            $display("FAIL lock_last_rsp rsp_h=%0d want %0d", h, (exp_idx[2] == 0) ? 12 : 25);
        end
        tick();
    endtask

    initial begin
        checks = 0; errors = 0; overlap_cnt = 0;
        rst = 1'b1; req = '0; req_lock = '0;
        f_in = '0; g_in = '0;
        frc_done = 1'b0; frc_h = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_no_starve();
        test_reset_in_wait();
        test_spurious_done();
        test_lock();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL gnt_rsp_overlap cycles=%0d want 0", overlap_cnt);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
